// File: rtl/multicycle_sequencer_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer (master)
// and the datapath / memory / mult-div side (slave).
interface multicycle_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       md_done;
  logic       branch_taken;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_req;
  logic       mem_we;
  logic       mem_byte;
  logic       iord;
  logic       reg_write;
  logic       link;
  logic       md_start;
  logic       halted;
  logic       err;
  logic [2:0] state;

  modport master (
    input  opcode, funct, mem_ready, md_done, branch_taken,
    output pc_write, pc_src, ir_write, mem_req, mem_we, mem_byte, iord,
           reg_write, link, md_start, halted, err, state
  );

  modport slave (
    output opcode, funct, mem_ready, md_done, branch_taken,
    input  pc_write, pc_src, ir_write, mem_req, mem_we, mem_byte, iord,
           reg_write, link, md_start, halted, err, state
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory and mult/div handshakes, a wait timeout and a sticky error halt.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_J, CLS_JAL, CLS_JR
  } cls_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  cls_e            cls_q, cls_d;
  logic            byte_q, byte_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  cls_e dec_cls;
  logic dec_halt, dec_md, dec_bad, dec_byte;

  logic       pc_write, ir_write, mem_req, mem_we, mem_byte, iord;
  logic       reg_write, link, md_start;
  logic [1:0] pc_src;
  logic       wait_expired;

  always_comb begin
    dec_cls  = CLS_ALU;
    dec_halt = 1'b0;
    dec_md   = 1'b0;
    dec_bad  = 1'b0;
    dec_byte = (bus.opcode == 6'b100000) || (bus.opcode == 6'b101000);
    case (bus.opcode)
      6'b000000:
        case (bus.funct)
          6'b001100:            dec_halt = 1'b1;
          6'b011000, 6'b011010: dec_md   = 1'b1;
          6'b001000:            dec_cls  = CLS_JR;
          default:              dec_cls  = CLS_ALU;
        endcase
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001010, 6'b001111:             dec_cls = CLS_ALU;
      6'b000100, 6'b000101, 6'b000110,
      6'b000111, 6'b000001:                        dec_cls = CLS_BRANCH;
      6'b000010:                                   dec_cls = CLS_J;
      6'b000011:                                   dec_cls = CLS_JAL;
      6'b100011, 6'b100000:                        dec_cls = CLS_LOAD;
      6'b101011, 6'b101000:                        dec_cls = CLS_STORE;
      default:                                     dec_bad = 1'b1;
    endcase
  end

  assign wait_expired = (cnt_q == TO_LAST);

  // The awaited handshake is tested before the timeout, so a same-cycle arrival wins.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    byte_d    = byte_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    ir_write  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    iord      = 1'b0;
    reg_write = 1'b0;
    link      = 1'b0;
    md_start  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        cls_d  = dec_cls;
        byte_d = dec_byte;
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_md) begin
          md_start = 1'b1;
          state_d  = S_MDWAIT;
        end else if (dec_bad) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_BRANCH: begin
            pc_write = bus.branch_taken;
            pc_src   = 2'b01;
            state_d  = S_FETCH;
          end
          CLS_J: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
          end
          CLS_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = 1'b1;
            link      = 1'b1;
            state_d   = S_FETCH;
          end
          CLS_JR: begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
            state_d  = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = (cls_q == CLS_STORE);
        mem_byte = byte_q;
        if (bus.mem_ready) begin
          state_d = (cls_q == CLS_STORE) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MDWAIT: begin
        if (bus.md_done) begin
          state_d = S_WB;
        end else if (wait_expired) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: ;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_ALU;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything is held at zero while reset is asserted, even mid-instruction.
  assign bus.pc_write  = rst_n & pc_write;
  assign bus.pc_src    = rst_n ? pc_src : 2'b00;
  assign bus.ir_write  = rst_n & ir_write;
  assign bus.mem_req   = rst_n & mem_req;
  assign bus.mem_we    = rst_n & mem_we;
  assign bus.mem_byte  = rst_n & mem_byte;
  assign bus.iord      = rst_n & iord;
  assign bus.reg_write = rst_n & reg_write;
  assign bus.link      = rst_n & link;
  assign bus.md_start  = rst_n & md_start;
  assign bus.halted    = rst_n & (state_q == S_HALT);
  assign bus.err       = rst_n & err_q;
  assign bus.state     = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic against an instruction-level reference model.
module tb_multicycle_sequencer;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       mem_byte;
    logic       iord;
    logic       reg_write;
    logic       link;
    logic       md_start;
    logic       halted;
    logic       err;
  } out_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       mr;
    logic       md;
    logic       bt;
    out_t       exp;
  } vec_t;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_J = 4;
  localparam int K_JAL = 5, K_JR = 6, K_MD = 7, K_HALT = 8, K_BAD = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready, md_done, branch_taken;
  out_t       got0, got1;

  int n_vec = 0;
  int n_err = 0;

  int m_st[2];
  int m_wait[2];
  bit m_err[2];

  multicycle_sequencer_if bus0 ();
  multicycle_sequencer_if bus1 ();

  assign bus0.opcode = opcode;        assign bus1.opcode = opcode;
  assign bus0.funct = funct;          assign bus1.funct = funct;
  assign bus0.mem_ready = mem_ready;  assign bus1.mem_ready = mem_ready;
  assign bus0.md_done = md_done;      assign bus1.md_done = md_done;
  assign bus0.branch_taken = branch_taken;
  assign bus1.branch_taken = branch_taken;

  assign got0 = {bus0.state, bus0.pc_write, bus0.pc_src, bus0.ir_write, bus0.mem_req,
                 bus0.mem_we, bus0.mem_byte, bus0.iord, bus0.reg_write, bus0.link,
                 bus0.md_start, bus0.halted, bus0.err};
  assign got1 = {bus1.state, bus1.pc_write, bus1.pc_src, bus1.ir_write, bus1.mem_req,
                 bus1.mem_we, bus1.mem_byte, bus1.iord, bus1.reg_write, bus1.link,
                 bus1.md_start, bus1.halted, bus1.err};

  multicycle_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_sequencer #(.MEM_TIMEOUT(8), .TO_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  function automatic out_t mk(int st, bit pcw, int pcs, bit irw, bit req, bit we, bit byt,
                              bit io, bit rw, bit lk, bit mds, bit hl, bit er);
    out_t o;
    o = {3'(st), pcw, 2'(pcs), irw, req, we, byt, io, rw, lk, mds, hl, er};
    return o;
  endfunction

  function automatic vec_t v(logic r, logic [5:0] op, logic [5:0] fn, logic mr, logic md,
                             logic bt, out_t e);
    vec_t x;
    x.rst_n = r; x.op = op; x.fn = fn; x.mr = mr; x.md = md; x.bt = bt; x.exp = e;
    return x;
  endfunction

  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b001100) return K_HALT;
      if (fn inside {6'b011000, 6'b011010}) return K_MD;
      if (fn == 6'b001000) return K_JR;
      return K_ALU;
    end
    if (op inside {6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                   6'b001111}) return K_ALU;
    if (op inside {6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001}) return K_BR;
    if (op == 6'b000010) return K_J;
    if (op == 6'b000011) return K_JAL;
    if (op inside {6'b100011, 6'b100000}) return K_LOAD;
    if (op inside {6'b101011, 6'b101000}) return K_STORE;
    return K_BAD;
  endfunction

  // Instruction-level reference: what this cycle shows and where the instruction goes next.
  task automatic model_step(input int d, input int tmo, output out_t o);
    int  k, nst;
    bit  waiting, hs;
    o = '0;
    if (rst_n !== 1'b1) begin
      m_st[d] = 0; m_wait[d] = 0; m_err[d] = 0;
      return;
    end
    k = kind_of(opcode, funct);
    nst = m_st[d];
    hs = 1'b0;
    waiting = (m_st[d] == 0) || (m_st[d] == 3) || (m_st[d] == 5);
    o.state  = 3'(m_st[d]);
    o.halted = (m_st[d] == 6);
    o.err    = m_err[d];
    case (m_st[d])
      0: begin
        o.mem_req = 1'b1;
        hs = mem_ready;
        if (mem_ready) begin o.ir_write = 1'b1; o.pc_write = 1'b1; nst = 1; end
      end
      1: begin
        if (k == K_HALT) nst = 6;
        else if (k == K_MD) begin o.md_start = 1'b1; nst = 5; end
        else if (k == K_BAD) begin nst = 6; m_err[d] = 1'b1; end
        else nst = 2;
      end
      2: begin
        case (k)
          K_LOAD, K_STORE: nst = 3;
          K_BR:  begin o.pc_src = 2'd1; o.pc_write = branch_taken; nst = 0; end
          K_J:   begin o.pc_src = 2'd2; o.pc_write = 1'b1; nst = 0; end
          K_JAL: begin o.pc_src = 2'd2; o.pc_write = 1'b1; o.reg_write = 1'b1; o.link = 1'b1; nst = 0; end
          K_JR:  begin o.pc_src = 2'd3; o.pc_write = 1'b1; nst = 0; end
          default: nst = 4;
        endcase
      end
      3: begin
        o.mem_req = 1'b1; o.iord = 1'b1;
        o.mem_we = (k == K_STORE);
        o.mem_byte = (opcode == 6'b100000) || (opcode == 6'b101000);
        hs = mem_ready;
        if (mem_ready) nst = (k == K_STORE) ? 0 : 4;
      end
      4: begin o.reg_write = 1'b1; nst = 0; end
      5: begin hs = md_done; if (md_done) nst = 4; end
      default: ;
    endcase
    if (waiting && !hs) begin
      if (m_wait[d] + 1 >= tmo) begin nst = 6; m_err[d] = 1'b1; end
      else m_wait[d] = m_wait[d] + 1;
    end
    if (nst != m_st[d]) m_wait[d] = 0;
    m_st[d] = nst;
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic md, input logic bt);
    @(posedge clk);
    #1;
    rst_n = r; opcode = op; funct = fn; mem_ready = mr; md_done = md; branch_taken = bt;
    #3;
  endtask

  initial begin
    vec_t tbl[$];
    out_t f_hit, f_wait, dec, exq, wb, zero, mem_rd;
    logic [5:0] pool_op[20];
    logic [5:0] pool_fn[20];
    int cnt, cnt2;
    bit seen;
    out_t e;

    rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0; md_done = 1'b0; branch_taken = 1'b0;

    zero   = '0;
    f_hit  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    f_wait = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    dec    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exq    = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb     = mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    mem_rd = mk(3, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    // addu, sb, beq x2, jal, jr, halt, illegal opcode; one row per cycle
    tbl.push_back(v(0, 6'h00, 6'h21, 1, 0, 0, zero));
    tbl.push_back(v(1, 6'h00, 6'h21, 1, 0, 0, f_hit));
    tbl.push_back(v(1, 6'h00, 6'h21, 1, 0, 0, dec));
    tbl.push_back(v(1, 6'h00, 6'h21, 1, 0, 0, exq));
    tbl.push_back(v(1, 6'h00, 6'h21, 1, 0, 0, wb));
    tbl.push_back(v(1, 6'h28, 6'h00, 1, 0, 0, f_hit));
    tbl.push_back(v(1, 6'h28, 6'h00, 1, 0, 0, dec));
    tbl.push_back(v(1, 6'h28, 6'h00, 1, 0, 0, exq));
    tbl.push_back(v(1, 6'h28, 6'h00, 1, 0, 0, mk(3, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 6'h04, 6'h00, 1, 0, 0, f_hit));
    tbl.push_back(v(1, 6'h04, 6'h00, 1, 0, 0, dec));
    tbl.push_back(v(1, 6'h04, 6'h00, 1, 0, 0, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 6'h04, 6'h00, 1, 0, 1, f_hit));
    tbl.push_back(v(1, 6'h04, 6'h00, 1, 0, 1, dec));
    tbl.push_back(v(1, 6'h04, 6'h00, 1, 0, 1, mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 6'h03, 6'h00, 1, 0, 0, f_hit));
    tbl.push_back(v(1, 6'h03, 6'h00, 1, 0, 0, dec));
    tbl.push_back(v(1, 6'h03, 6'h00, 1, 0, 0, mk(2, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0)));
    tbl.push_back(v(1, 6'h00, 6'h08, 1, 0, 0, f_hit));
    tbl.push_back(v(1, 6'h00, 6'h08, 1, 0, 0, dec));
    tbl.push_back(v(1, 6'h00, 6'h08, 1, 0, 0, mk(2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 6'h00, 6'h0C, 1, 0, 0, f_hit));
    tbl.push_back(v(1, 6'h00, 6'h0C, 1, 1, 1, dec));
    tbl.push_back(v(1, 6'h00, 6'h0C, 1, 1, 1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(v(1, 6'h23, 6'h18, 1, 1, 1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(v(0, 6'h23, 6'h18, 1, 1, 1, zero));
    tbl.push_back(v(1, 6'h3F, 6'h00, 0, 0, 0, f_wait));
    tbl.push_back(v(1, 6'h3F, 6'h00, 1, 0, 0, f_hit));
    tbl.push_back(v(1, 6'h3F, 6'h00, 1, 0, 0, dec));
    tbl.push_back(v(1, 6'h3F, 6'h00, 1, 1, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)));
    tbl.push_back(v(0, 6'h3F, 6'h00, 1, 1, 0, zero));

    foreach (tbl[i]) begin
      tick(tbl[i].rst_n, tbl[i].op, tbl[i].fn, tbl[i].mr, tbl[i].md, tbl[i].bt);
      check($sformatf("table[%0d]", i), got0, tbl[i].exp);
    end

    // lw with mem_ready raised on the fourth MEM cycle
    tick(0, 6'h23, 6'h00, 0, 0, 0);
    tick(1, 6'h23, 6'h00, 1, 0, 0); check("lw_fetch", got0, f_hit);
    tick(1, 6'h23, 6'h00, 0, 0, 0); check("lw_decode", got0, dec);
    tick(1, 6'h23, 6'h00, 0, 0, 0); check("lw_exec", got0, exq);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 6'h23, 6'h00, (i == 3), 0, 0);
      if (got0 === mem_rd) cnt++;
    end
    check_int("lw_mem_cycles", cnt, 4);
    tick(1, 6'h23, 6'h00, 0, 0, 0); check("lw_wb", got0, wb);
    tick(1, 6'h23, 6'h00, 0, 0, 0); check("lw_back_fetch", got0, f_wait);

    // mult with md_done on the tenth MDWAIT cycle
    tick(0, 6'h00, 6'h18, 0, 0, 0);
    tick(1, 6'h00, 6'h18, 1, 0, 0); check("mult_fetch", got0, f_hit);
    tick(1, 6'h00, 6'h18, 0, 0, 0);
    check("mult_decode", got0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    cnt = 0; cnt2 = int'(got0.md_start);
    for (int i = 0; i < 10; i++) begin
      tick(1, 6'h00, 6'h18, 0, (i == 9), 0);
      if (got0.state == 3'd5) cnt++;
      cnt2 += int'(got0.md_start);
    end
    tick(1, 6'h00, 6'h18, 0, 0, 0); check("mult_wb", got0, wb);
    cnt2 += int'(got0.md_start);
    check_int("mult_mdwait_cycles", cnt, 10);
    check_int("mult_md_start_pulses", cnt2, 1);
    tick(1, 6'h00, 6'h18, 0, 0, 0); check("mult_back_fetch", got0, f_wait);

    // timeout-8 instance: no mem_ready in FETCH
    tick(0, 6'h00, 6'h21, 0, 0, 0);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1, 6'h00, 6'h21, 0, 0, 0);
      if (got1.state == 3'd6) seen = 1'b1;
      else if (got1.mem_req) cnt++;
    end
    check_int("to8_halt_reached", int'(seen), 1);
    check_int("to8_fetch_cycles", cnt, 8);
    check("to8_halt_out", got1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tick(1, 6'h00, 6'h21, 1, 1, 1);
    check("to8_halt_sticky", got1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

    // handshake arriving on the last allowed cycle wins over the timeout
    tick(0, 6'h00, 6'h21, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(1, 6'h00, 6'h21, 0, 0, 0);
    check("to8_last_wait", got1, f_wait);
    tick(1, 6'h00, 6'h21, 1, 0, 0); check("to8_edge_win", got1, f_hit);
    tick(1, 6'h00, 6'h21, 0, 0, 0); check("to8_edge_decode", got1, dec);

    // randomized traffic on both instances against the reference model
    pool_op = '{6'h00, 6'h00, 6'h09, 6'h0D, 6'h0F, 6'h0A, 6'h23, 6'h20, 6'h2B, 6'h28,
                6'h04, 6'h01, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h10};
    pool_fn = '{6'h21, 6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h18, 6'h1A, 6'h0C, 6'h00, 6'h00};
    for (int c = 0; c < 3000; c++) begin
      int idx;
      logic r;
      logic [5:0] op, fn;
      r = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      op = opcode; fn = funct;
      if (!r || ((m_st[0] == 0 || m_st[0] == 6) && (m_st[1] == 0 || m_st[1] == 6))) begin
        idx = $urandom_range(0, 19);
        op = pool_op[idx];
        fn = (pool_op[idx] == 6'h00) ? pool_fn[idx] : 6'($urandom);
      end
      tick(r, op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)));
      model_step(0, 255, e); check($sformatf("rand255[%0d]", c), got0, e);
      model_step(1, 8, e);   check($sformatf("rand8[%0d]", c), got1, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the MIPS core: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.
- Classifies the current IR opcode/funct and drives the strobes for the PC, IR, register file, memory port and mult/div unit.
- Handshakes with a variable-latency memory and an iterative mult/div unit.
- Traps unknown opcodes and stuck handshakes into a sticky error halt.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles in FETCH, MEM or MDWAIT before error halt (≥1).
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory access complete (one-cycle pulse or level)
- md_done  in  1  mult/div result valid
- branch_taken  in  1  ALU branch condition for the current branch
- pc_write  out  1  PC load strobe
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- ir_write  out  1  IR load strobe
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  store
- mem_byte  out  1  byte access (lb/sb)
- iord  out  1  0 = PC address, 1 = ALU address
- reg_write  out  1  register-file write strobe
- link  out  1  write PC to R[31] (jal)
- md_start  out  1  one-cycle mult/div start pulse
- halted  out  1  sticky halt
- err  out  1  sticky error (unknown opcode or timeout)
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5, HALT=6

Behaviour:
- Reset (rst_n low at a clock edge): state=FETCH, all outputs 0, timeout counter 0, class register cleared.
- Reset mid-instruction aborts it with no further strobes.
- Outputs are combinational from state, latched class and the handshake inputs. All strobes are forced 0 while rst_n is low.

FETCH:
- mem_req=1, iord=0.
- On mem_ready: ir_write=1, pc_write=1, pc_src=00 for that cycle; next state DECODE.

DECODE (exactly 1 cycle): latch the class, then transition:
- opcode 000000, funct 001100 -> HALT.
- opcode 000000, funct 011000/011010 (mult/div) -> md_start=1 this cycle; next MDWAIT.
- opcode 000000, funct 001000 (jr) -> EXEC.
- Other opcode-000000 funct values -> EXEC (ALU).
- I-ALU opcodes 001000, 001001, 001100, 001101, 001110, 001010, 001111 -> EXEC.
- Branch opcodes 000100, 000101, 000110, 000111, 000001 -> EXEC.
- Jumps 000010 (j), 000011 (jal) -> EXEC.
- Loads 100011, 100000 and stores 101011, 101000 -> EXEC.
- Any other opcode -> HALT with err=1.

EXEC (exactly 1 cycle):
- ALU class: no strobes; next WB.
- Load/store: address computation; next MEM.
- Branch: pc_write=branch_taken, pc_src=01; next FETCH.
- j: pc_write=1, pc_src=10; next FETCH.
- jal: as j, plus reg_write=1 and link=1; next FETCH.
- jr: pc_write=1, pc_src=11; next FETCH.

MEM:
- mem_req=1, iord=1; mem_we=1 for stores; mem_byte=1 for lb/sb.
- On mem_ready: stores go to FETCH, loads go to WB.

MDWAIT: wait for md_done, then go to WB.

WB: reg_write=1 for 1 cycle; next FETCH.

HALT:
- halted=1, all strobes 0, all inputs ignored.
- Left only by reset.

Timeout:
- The counter clears on every state entry and increments each cycle in FETCH, MEM and MDWAIT while the awaited handshake is low.
- When it reaches MEM_TIMEOUT, the next state is HALT with err=1.
- If the handshake arrives in the same cycle, the handshake wins.

Ignored inputs and sticky flags:
- mem_ready outside FETCH/MEM and md_done outside MDWAIT are ignored.
- err implies halted. Both stay set until reset.

Latency with zero-wait handshakes:
- ALU: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch/jump: 3 cycles.
- Mult/div: 4 cycles plus the md_done wait.

Test Plan:
1. Reset, then addu (opcode 000000, funct 100001) with mem_ready=1 from the start -> state 0,1,2,4,0. ir_write/pc_write pulse in cycle 0 only; reg_write high only in the WB cycle.
2. lw (100011) with mem_ready raised 3 cycles into MEM -> mem_req=1, iord=1 for 4 MEM cycles, mem_we=0, then WB reg_write=1 once.
3. sb (101000) -> MEM with mem_we=1, mem_byte=1; returns to FETCH with no reg_write.
4. beq (000100) run twice with branch_taken=0 and then 1 -> EXEC shows pc_src=01 and pc_write=0, then 1. jal (000011) -> pc_write=1, pc_src=10, reg_write=1, link=1 in EXEC.
5. mult (funct 011000) with md_done after 10 cycles -> md_start exactly 1 pulse, 10 MDWAIT cycles, WB, FETCH. Rerun with MEM_TIMEOUT=8, mem_ready never asserted in FETCH -> halted=err=1 after 8 cycles, mem_req drops to 0.
6. Halt funct 001100 -> state 6, halted=1, err=0, outputs frozen under random inputs. Opcode 111111 -> err=1. rst_n low 1 cycle in any state -> state 0 and all outputs 0 on the next edge.
